// File: rtl/conv_frame_driver_if.sv
// Handshake/bus bundle between the frame driver and its neighbours:
// pixel stream in, bank FSM/memory control, result stream out.
// master = frame driver side, slave = pixel source / FSM / memory / result sink side.
interface conv_frame_driver_if #(
  parameter int NB_IMAGE = 10,
  parameter int NB_DATA  = 8
);
  // upstream pixel stream
  logic [NB_DATA-1:0]  i_pix_data;
  logic                i_pix_valid;
  logic                o_pix_ready;
  // bank FSM / memory control
  logic                o_load;
  logic                o_SoP;
  logic                o_valid;
  logic [NB_DATA-1:0]  o_wdata;
  logic [NB_IMAGE-1:0] o_imgLength;
  logic                i_changeBlock;
  logic                i_EoP;
  logic [NB_DATA-1:0]  i_rdata;
  // downstream result stream
  logic [NB_DATA-1:0]  o_res_data;
  logic                o_res_valid;
  logic                o_res_last;
  logic                i_res_ready;

  modport master (
    input  i_pix_data, i_pix_valid, i_changeBlock, i_EoP, i_rdata, i_res_ready,
    output o_pix_ready, o_load, o_SoP, o_valid, o_wdata, o_imgLength,
           o_res_data, o_res_valid, o_res_last
  );

  modport slave (
    output i_pix_data, i_pix_valid, i_changeBlock, i_EoP, i_rdata, i_res_ready,
    input  o_pix_ready, o_load, o_SoP, o_valid, o_wdata, o_imgLength,
           o_res_data, o_res_valid, o_res_last
  );
endinterface

// File: rtl/conv_frame_driver.sv
// Purpose: host-side sequencer for one convolution bank: load a column, run SoP, read back passes.
// Latency: all outputs registered; one o_valid pulse per accepted pixel / transferred sample.
// Backpressure: pixel ready only between pulses; result held stable while i_res_ready is low.
// Ports: i_CLK/i_reset (sync, active high), i_start + i_imgLength start a frame,
//   o_busy/o_error status, bus (master) carries pixel in, FSM/memory control, result out.
module conv_frame_driver #(
  parameter int NB_IMAGE = 10,
  parameter int NB_DATA  = 8,
  parameter int MEM_LAT  = 1,
  parameter int TIMEOUT  = 1023
) (
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_IMAGE-1:0] i_imgLength,
  output logic                o_busy,
  output logic                o_error,
  conv_frame_driver_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + MEM_LAT + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  // Address moves the cycle after a pulse, data lands MEM_LAT later.
  localparam logic [TW-1:0] LAT_LAST = TW'(MEM_LAT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT_LD, S_SOP, S_PROC, S_REL,
    S_RD_WAIT, S_RD_OUT, S_RD_END, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NB_IMAGE-1:0] len_q, len_d;
  logic [NB_IMAGE-1:0] idx_q, idx_d;       // pixel count in LOAD, address index a in read-back
  logic [TW-1:0]       wait_q, wait_d;     // timeout counter, or latency counter in RD_WAIT
  logic                seen_q, seen_d;     // RD_END: changeBlock high already observed
  logic                load_q, load_d;
  logic                sop_q, sop_d;
  logic                vld_q, vld_d;
  logic [NB_DATA-1:0]  wdata_q, wdata_d;
  logic                pix_rdy_q, pix_rdy_d;
  logic [NB_DATA-1:0]  res_dat_q, res_dat_d;
  logic                res_vld_q, res_vld_d;
  logic                res_last_q, res_last_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic                timed;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    seen_d     = seen_q;
    load_d     = load_q;
    sop_d      = sop_q;
    vld_d      = 1'b0;              // o_valid is always a single-cycle pulse
    wdata_d    = wdata_q;
    res_dat_d  = res_dat_q;
    res_vld_d  = res_vld_q;
    res_last_d = res_last_q;
    error_d    = error_q;
    timed      = (state_q == S_WAIT_LD) || (state_q == S_PROC) ||
                 (state_q == S_REL) || (state_q == S_RD_END);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_imgLength >= NB_IMAGE'(3)) begin
            len_d   = i_imgLength;
            idx_d   = '0;
            error_d = 1'b0;
            load_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (pix_rdy_q && bus.i_pix_valid) begin
          wdata_d = bus.i_pix_data;
          vld_d   = 1'b1;
          idx_d   = idx_q + NB_IMAGE'(1);
        end else if ((idx_q == len_q) && !vld_q) begin
          // Extra pulse with zero data closes the column (L+1 pulses).
          wdata_d = '0;
          vld_d   = 1'b1;
          state_d = S_WAIT_LD;
        end
      end
      S_WAIT_LD: begin
        if (bus.i_changeBlock) begin
          load_d  = 1'b0;
          state_d = S_SOP;
        end
      end
      S_SOP: begin
        if (!bus.i_changeBlock) begin
          sop_d   = 1'b1;
          state_d = S_PROC;
        end
      end
      S_PROC: begin
        if (bus.i_changeBlock) begin
          sop_d   = 1'b0;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (!bus.i_changeBlock) begin
          idx_d   = '0;
          state_d = bus.i_EoP ? S_RD_WAIT : S_DONE;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == LAT_LAST) begin
          res_dat_d  = bus.i_rdata;
          res_vld_d  = 1'b1;
          res_last_d = (idx_q == len_q - NB_IMAGE'(2));
          state_d    = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        if (bus.i_res_ready) begin
          res_vld_d  = 1'b0;
          res_last_d = 1'b0;
          vld_d      = 1'b1;
          idx_d      = idx_q + NB_IMAGE'(1);
          seen_d     = 1'b0;
          state_d    = res_last_q ? S_RD_END : S_RD_WAIT;
        end
      end
      S_RD_END: begin
        if (!seen_q) begin
          seen_d = bus.i_changeBlock;
        end else if (!bus.i_changeBlock) begin
          idx_d   = '0;
          state_d = bus.i_EoP ? S_RD_WAIT : S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A stuck handshake abandons the frame; a real advance this cycle wins.
    if (timed && (state_d == state_q) && (wait_q == TMO_LAST)) begin
      error_d = 1'b1;
      load_d  = 1'b0;
      sop_d   = 1'b0;
      state_d = S_IDLE;
    end

    wait_d    = (state_d != state_q) ? '0 : wait_q + TW'(1);
    busy_d    = (state_d != S_IDLE);
    // No accept while a pulse is going out or in the low cycle right after it.
    pix_rdy_d = (state_d == S_LOAD) && !vld_d && !vld_q && (idx_d < len_d);
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      wait_q     <= '0;
      seen_q     <= 1'b0;
      load_q     <= 1'b0;
      sop_q      <= 1'b0;
      vld_q      <= 1'b0;
      wdata_q    <= '0;
      pix_rdy_q  <= 1'b0;
      res_dat_q  <= '0;
      res_vld_q  <= 1'b0;
      res_last_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      seen_q     <= seen_d;
      load_q     <= load_d;
      sop_q      <= sop_d;
      vld_q      <= vld_d;
      wdata_q    <= wdata_d;
      pix_rdy_q  <= pix_rdy_d;
      res_dat_q  <= res_dat_d;
      res_vld_q  <= res_vld_d;
      res_last_q <= res_last_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign bus.o_pix_ready = pix_rdy_q;
  assign bus.o_load      = load_q;
  assign bus.o_SoP       = sop_q;
  assign bus.o_valid     = vld_q;
  assign bus.o_wdata     = wdata_q;
  assign bus.o_imgLength = len_q;
  assign bus.o_res_data  = res_dat_q;
  assign bus.o_res_valid = res_vld_q;
  assign bus.o_res_last  = res_last_q;
  assign o_busy          = busy_q;
  assign o_error         = error_q;
endmodule

// File: tb/tb_conv_frame_driver.sv
module tb_conv_frame_driver;
  localparam int NB_IMAGE = 10;
  localparam int NB_DATA  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, start, start_t;
  logic [NB_IMAGE-1:0] len, len_t;
  logic                busy, error, busy_t, error_t;
  logic [NB_DATA-1:0]  addr;
  logic                mem_clr;

  conv_frame_driver_if #(.NB_IMAGE(NB_IMAGE), .NB_DATA(NB_DATA)) bus ();
  conv_frame_driver_if #(.NB_IMAGE(NB_IMAGE), .NB_DATA(NB_DATA)) bus_t ();

  conv_frame_driver #(.NB_IMAGE(NB_IMAGE), .NB_DATA(NB_DATA), .MEM_LAT(1), .TIMEOUT(1023)) dut (
    .i_CLK(clk), .i_reset(rst), .i_start(start), .i_imgLength(len),
    .o_busy(busy), .o_error(error), .bus(bus.master)
  );

  conv_frame_driver #(.NB_IMAGE(NB_IMAGE), .NB_DATA(NB_DATA), .MEM_LAT(1), .TIMEOUT(15)) dut_t (
    .i_CLK(clk), .i_reset(rst), .i_start(start_t), .i_imgLength(len_t),
    .o_busy(busy_t), .o_error(error_t), .bus(bus_t.master)
  );

  // Bank memory model: address advances on each o_valid pulse, data = addr*3, one cycle latency.
  always @(posedge clk) begin
    if (mem_clr) addr <= '0;
    else if (bus.o_valid) addr <= addr + 8'd1;
    bus.i_rdata <= NB_DATA'(addr * 8'd3);
  end

  int n_chk = 0;
  int n_err = 0;
  int pulse_cnt = 0, gap_err = 0, sop_err = 0, stall_pulse_err = 0;
  logic prev_valid = 1'b0;
  logic [NB_DATA-1:0] wq[$];
  logic [NB_DATA-1:0] rq[$];
  logic               lq[$];

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      pulse_cnt++;
      wq.push_back(bus.o_wdata);
      if (prev_valid) gap_err++;
      if (bus.o_SoP) sop_err++;
      if (bus.o_res_valid) stall_pulse_err++;
    end
    prev_valid = (bus.o_valid === 1'b1);
    if (bus.o_res_valid === 1'b1 && bus.i_res_ready === 1'b1) begin
      rq.push_back(bus.o_res_data);
      lq.push_back(bus.o_res_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pc, sop_bad, n, cyc;
    logic [31:0] got;
    rst = 1'b1; start = 1'b0; start_t = 1'b0; len = '0; len_t = 10'd3; mem_clr = 1'b1;
    bus.i_pix_valid = 1'b0; bus.i_pix_data = '0; bus.i_changeBlock = 1'b0;
    bus.i_EoP = 1'b0; bus.i_res_ready = 1'b0;
    bus_t.i_pix_valid = 1'b1; bus_t.i_pix_data = 8'd5; bus_t.i_changeBlock = 1'b0;
    bus_t.i_EoP = 1'b0; bus_t.i_res_ready = 1'b0; bus_t.i_rdata = '0;
    repeat (3) tick();

    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_load", bus.o_load, 0);
    check("rst_sop", bus.o_SoP, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_ready", bus.o_pix_ready, 0);
    check("rst_len", bus.o_imgLength, 0);
    check("rst_res_valid", bus.o_res_valid, 0);
    rst = 1'b0;
    tick();

    // ---- load L=8, pixels 1..8 streamed continuously
    len = 10'd8; start = 1'b1; tick(); start = 1'b0; len = 10'd5;
    check("start_busy", busy, 1);
    check("start_load", bus.o_load, 1);
    check("latched_len", bus.o_imgLength, 8);
    bus.i_pix_valid = 1'b1;
    for (int p = 1; p <= 8; p++) begin
      bus.i_pix_data = NB_DATA'(p);
      for (int w = 0; w < 10 && !bus.o_pix_ready; w++) tick();
      tick();
    end
    bus.i_pix_valid = 1'b0;
    for (int i = 0; i < 20 && pulse_cnt < 9; i++) tick();
    repeat (3) tick();
    check("load_pulses", pulse_cnt, 9);
    check("load_gap", gap_err, 0);
    for (int k = 0; k < 9; k++) begin
      got = (k < wq.size()) ? 32'(wq[k]) : 32'hFFFF;
      check($sformatf("wdata%0d", k), got, (k < 8) ? k + 1 : 0);
    end
    check("wait_ld_load", bus.o_load, 1);
    check("wait_ld_ready", bus.o_pix_ready, 0);
    bus.i_changeBlock = 1'b1; tick();
    check("load_fall", bus.o_load, 0);
    tick();
    check("sop_wait_cb_low", bus.o_SoP, 0);

    // ---- processing: SoP high for 20 cycles until changeBlock
    bus.i_changeBlock = 1'b0; tick();
    check("sop_rise", bus.o_SoP, 1);
    bus.i_pix_valid = 1'b1; start = 1'b1; tick(); start = 1'b0;
    sop_bad = 0;
    for (int i = 0; i < 19; i++) begin
      if (!bus.o_SoP || bus.o_pix_ready) sop_bad++;
      tick();
    end
    bus.i_pix_valid = 1'b0;
    check("sop_held", sop_bad, 0);
    check("busy_start_ignored", bus.o_imgLength, 8);
    bus.i_changeBlock = 1'b1;
    check("sop_at_cb", bus.o_SoP, 1);
    tick();
    check("sop_fall", bus.o_SoP, 0);
    check("proc_no_pulse", pulse_cnt, 9);
    check("sop_pulse", sop_err, 0);

    // ---- read-back: two passes, stall at sample 3 of the first
    bus.i_EoP = 1'b1;
    repeat (2) tick();
    bus.i_changeBlock = 1'b0; mem_clr = 1'b0;
    for (int pi = 0; pi < 2; pi++) begin
      for (int s = 0; s < 7; s++) begin
        for (int w = 0; w < 20 && !bus.o_res_valid; w++) tick();
        if (pi == 0 && s == 3) begin
          pc = pulse_cnt;
          repeat (5) tick();
          check("stall_data", bus.o_res_data, 9);
          check("stall_valid", bus.o_res_valid, 1);
          check("stall_pulse", pulse_cnt, pc);
        end
        bus.i_res_ready = 1'b1; tick(); bus.i_res_ready = 1'b0;
      end
      repeat (4) tick();
      bus.i_changeBlock = 1'b1; mem_clr = 1'b1;
      if (pi == 1) bus.i_EoP = 1'b0;
      repeat (2) tick();
      bus.i_changeBlock = 1'b0; mem_clr = 1'b0;
    end
    for (int w = 0; w < 20 && busy; w++) tick();
    check("done_idle", busy, 0);
    check("done_error", error, 0);
    check("read_pulses", pulse_cnt, 23);
    check("read_samples", rq.size(), 14);
    check("read_stall_pulse", stall_pulse_err, 0);
    check("read_gap", gap_err, 0);
    for (int k = 0; k < 14; k++) begin
      got = (k < rq.size()) ? 32'(rq[k]) : 32'hFFFF;
      check($sformatf("res%0d", k), got, (k % 7) * 3);
      got = (k < lq.size()) ? 32'(lq[k]) : 32'hFFFF;
      check($sformatf("last%0d", k), got, (k % 7 == 6) ? 1 : 0);
    end

    // ---- reset in the middle of LOAD
    len = 10'd8; start = 1'b1; tick(); start = 1'b0;
    bus.i_pix_valid = 1'b1; bus.i_pix_data = 8'h55;
    repeat (4) tick();
    check("abort_in_load", bus.o_load, 1);
    rst = 1'b1; tick();
    check("abort_load", bus.o_load, 0);
    check("abort_valid", bus.o_valid, 0);
    check("abort_wdata", bus.o_wdata, 0);
    check("abort_ready", bus.o_pix_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_len", bus.o_imgLength, 0);
    rst = 1'b0; bus.i_pix_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_load", bus.o_load, 1);
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // ---- illegal length
    pc = pulse_cnt;
    len = 10'd2; start = 1'b1; tick(); start = 1'b0;
    check("illegal_error", error, 1);
    check("illegal_busy", busy, 0);
    repeat (5) tick();
    check("illegal_pulses", pulse_cnt, pc);
    check("illegal_load", bus.o_load, 0);

    // ---- timeout in WAIT_LD (TIMEOUT=15 instance, changeBlock never rises)
    len_t = 10'd3; start_t = 1'b1; tick(); start_t = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      if (bus_t.o_valid) n++;
      if (n < 4) tick();
    end
    check("tmo_pulses", n, 4);
    cyc = 0;
    for (int i = 0; i < 40 && !error_t; i++) begin
      tick();
      cyc++;
    end
    check("tmo_cycle", cyc, 15);
    check("tmo_error", error_t, 1);
    check("tmo_load", bus_t.o_load, 0);
    check("tmo_idle", busy_t, 0);
    start_t = 1'b1; tick(); start_t = 1'b0;
    check("tmo_clear", error_t, 0);
    check("tmo_restart", busy_t, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_frame_driver.md
Name: conv_frame_driver

Overview:
- Host-side sequencer that drives the control/address FSM of one convolution memory bank from the other end of its handshake.
- Accepts an image column from an upstream pixel stream and loads it using pulsed valids.
- Runs the processing pass (SoP) and waits for block completion.
- Reads back the result passes while EoP is high and streams samples out with backpressure. Sits between the host GPIO/stream logic and the FSM/memory bank.

Parameters:
- NB_IMAGE, 10, width of image length.
- NB_DATA, 8, pixel/result width.
- MEM_LAT, 1, cycles from address change to valid read data.
- TIMEOUT, 1023, max cycles waiting for a block-change before error.

Ports:
- i_CLK  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_start  in  1  start one frame (sampled in IDLE only).
- i_imgLength  in  NB_IMAGE  column length L; latched at start.
- i_pix_data  in  NB_DATA  upstream pixel.
- i_pix_valid  in  1  upstream pixel valid.
- o_pix_ready  out  1  pixel accepted when valid&ready.
- o_load  out  1  load request to FSM.
- o_SoP  out  1  start-of-process to FSM.
- o_valid  out  1  single-cycle advance pulse to FSM.
- o_wdata  out  NB_DATA  pixel toward memory write port.
- o_imgLength  out  NB_IMAGE  latched L.
- i_changeBlock  in  1  FSM block-complete flag.
- i_EoP  in  1  FSM read-back pending.
- i_rdata  in  NB_DATA  memory read data.
- o_res_data  out  NB_DATA  result sample.
- o_res_valid  out  1  result valid.
- o_res_last  out  1  last sample of a read pass.
- i_res_ready  in  1  downstream ready.
- o_busy  out  1  not in IDLE.
- o_error  out  1  sticky timeout flag; cleared by reset or next i_start.

Behaviour:
- Reset: all outputs 0, o_imgLength 0, state IDLE, counters 0. Reset mid-frame aborts immediately; the next start is legal one cycle after reset drops.
- o_valid pulse rule:
  - High exactly 1 cycle.
  - At least 1 low cycle between pulses, because the FSM counts rising edges.
  - Never asserted while o_SoP=1.
- States:
  - IDLE:
    - o_busy=0.
    - On i_start with L>=3: latch L, clear o_error, go LOAD.
    - L<3: set o_error, stay IDLE.
  - LOAD:
    - o_load=1.
    - o_pix_ready=1 only when no pulse is pending and no pulse was issued last cycle.
    - On accept: o_wdata<=pixel, pulse o_valid next cycle, pixel count+1.
    - After L pixels, issue one terminating pulse with o_wdata=0 (L+1 pulses total). Go WAIT_LD.
  - WAIT_LD:
    - Hold o_load until i_changeBlock=1, then drop o_load and go SOP.
  - SOP:
    - Wait until i_changeBlock=0, then assert o_SoP and go PROC.
  - PROC:
    - Hold o_SoP=1 until i_changeBlock=1, then go REL with o_SoP=0 the following cycle.
  - REL:
    - Wait i_changeBlock=0.
    - If i_EoP=1, go RD_WAIT with address index a=0; else go DONE.
  - RD_WAIT:
    - Wait MEM_LAT+1 cycles after the last pulse (or after entering), then go RD_OUT.
  - RD_OUT:
    - o_res_data<=i_rdata, o_res_valid=1, o_res_last=(a==L-2).
    - Hold until i_res_ready; output is stable while stalled.
    - On transfer, pulse o_valid; a+1.
    - If a was L-2, go RD_END; else go RD_WAIT.
    - Each pass: L-1 samples, L-1 pulses.
  - RD_END:
    - Wait i_changeBlock=1 then 0.
    - i_EoP still 1: new pass, a=0, go RD_WAIT. Else go DONE.
  - DONE:
    - One cycle, o_busy=0 next cycle, return to IDLE.
- Timeout:
  - Counter runs in WAIT_LD, PROC, REL and RD_END; it is cleared on each state entry.
  - Reaching TIMEOUT: o_error=1, drop o_load/o_SoP, go IDLE.
- Simultaneous events:
  - i_start while busy: ignored.
  - i_pix_valid outside LOAD: ignored (ready=0).
  - i_changeBlock already 1 on entry to WAIT_LD: advance that cycle.
- Width: pixel and sample counters are NB_IMAGE bits. Comparisons use the latched L; later changes to i_imgLength have no effect on a running frame.

Test Plan:
- Load timing: L=8, pixels 1..8 streamed continuously. Expect 9 o_valid pulses each separated by ≥1 low cycle, o_wdata sequence 1..8 then 0, o_load falling the cycle after i_changeBlock rises.
- Processing: after load, FSM model raises changeBlock 20 cycles into SoP. Expect o_SoP high from the cycle after changeBlock=0 until one cycle after changeBlock=1, with no o_valid during it.
- Read-back: EoP high for 2 passes with L=8, memory returns addr*3. Expect 2×7 samples 0,3,…,18, o_res_last on each 7th, 14 pulses total, then DONE.
- Backpressure: i_res_ready low 5 cycles at sample 3. Expect o_res_data held, no pulse until the ready transfer.
- Timeout: TIMEOUT=15, changeBlock never asserted in WAIT_LD. Expect o_error=1 at cycle 15, o_load=0, state IDLE; the next i_start clears o_error.
- Reset/illegal: reset asserted mid-LOAD gives all outputs 0 next cycle. i_start with L=2 sets o_error and produces no pulses.
